// File: rtl/bcd_timer_pkg.sv
// ============================================================================
//  Module   : bcd_timer_pkg
//  Purpose  : Shared state encodings, BCD constants and the load-value digit
//             clamp for the BCD down-timer.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

package bcd_timer_pkg;

  // FSM state encodings (visible on the state output).
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Largest legal BCD digit.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Illegal BCD codes (A..F) on a loaded digit saturate to 9.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_dec.sv
// ============================================================================
//  Module   : bcd_digit_dec
//  Purpose  : One combinational BCD digit of a borrow-chained decrementer.
//             A zero digit receiving a borrow wraps to 9 and passes the
//             borrow on; a nonzero digit decrements and absorbs it.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

module bcd_digit_dec
  import bcd_timer_pkg::*;
(
  input  logic [3:0] d_in,
  input  logic       borrow_in,
  output logic [3:0] d_out,
  output logic       borrow_out
);

  logic w_is_zero;

  assign w_is_zero = (d_in == 4'd0);

  // Digit update and borrow propagation for a single decade.
  always_comb begin
    d_out      = d_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (w_is_zero) begin
        d_out      = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        d_out = d_in - 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_down_timer.sv
// ============================================================================
//  Module   : bcd_down_timer
//  Purpose  : Multi-digit BCD countdown with IDLE/PAUSE/RUN/DONE control,
//             optional auto-reload, a one-cycle done pulse and an LED bank
//             that lights while the countdown has expired.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int LED_WIDTH  = 16
) (
  input  logic                    clk_d,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    en,
  input  logic                    auto_reload,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [1:0]              state,
  output logic                    busy,
  output logic                    done,
  output logic [LED_WIDTH-1:0]    leds
);

  localparam int c_data_w = 4 * NUM_DIGITS;

  logic [c_data_w-1:0] r_count;
  logic [c_data_w-1:0] r_reload;
  logic [1:0]          r_state;
  logic                r_done;

  logic [c_data_w-1:0] w_count_nxt;
  logic [c_data_w-1:0] w_reload_nxt;
  logic [1:0]          w_state_nxt;
  logic                w_done_nxt;

  logic [c_data_w-1:0] w_clamped;
  logic [c_data_w-1:0] w_dec;
  logic [NUM_DIGITS:0] w_borrow;
  logic                w_count_zero;
  logic                w_dec_zero;
  logic                w_load_zero;

  // Digit 0 always decrements; each stage borrows from the one above.
  assign w_borrow[0] = 1'b1;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    bcd_digit_dec u_dec (
      .d_in      (r_count[4*gi +: 4]),
      .borrow_in (w_borrow[gi]),
      .d_out     (w_dec[4*gi +: 4]),
      .borrow_out(w_borrow[gi+1])
    );
    assign w_clamped[4*gi +: 4] = clamp_digit(load_val[4*gi +: 4]);
  end

  // The borrow ripples out of the top digit only when every digit is zero,
  // so the chain's carry-out doubles as the count==0 detector.
  assign w_count_zero = w_borrow[NUM_DIGITS];
  assign w_dec_zero   = (w_dec == '0);
  assign w_load_zero  = (w_clamped == '0);

  // State register.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: clr beats load, load beats normal sequencing.
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = IDLE;
    end else if (load) begin
      w_state_nxt = w_load_zero ? IDLE : PAUSE;
    end else begin
      case (r_state)
        PAUSE: if (en) w_state_nxt = RUN;
        RUN: begin
          if (!en) begin
            w_state_nxt = PAUSE;
          end else if (!w_count_zero && w_dec_zero && !auto_reload) begin
            w_state_nxt = DONE;
          end
        end
        default: w_state_nxt = r_state;  // IDLE and DONE wait for clr/load
      endcase
    end
  end

  // State-decoded outputs, driven only from the registered state.
  always_comb begin
    busy = (r_state == RUN);
    leds = {LED_WIDTH{r_state == DONE}};
  end

  // Datapath next values: count, reload value and the done pulse.
  always_comb begin
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    if (clr) begin
      w_count_nxt = '0;
    end else if (load) begin
      w_count_nxt  = w_clamped;
      w_reload_nxt = w_clamped;
    end else if (r_state == RUN && en) begin
      if (w_count_zero) begin
        // Zero held from the previous pass: restart without a done pulse.
        w_count_nxt = r_reload;
      end else begin
        w_count_nxt = w_dec;
        w_done_nxt  = w_dec_zero;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign digits = r_count;
  assign state  = r_state;
  assign done   = r_done;

endmodule

`default_nettype wire
